// File: rtl/dff_pipe_sr_pkg.sv
// Shared helpers for the elastic register pipeline: per-stage handshake and
// valid-bit update rules, used by both the ready chain and the stage cells.
package dff_pipe_sr_pkg;

    function automatic logic stage_accept(
        input logic ce,
        input logic valid,
        input logic leave
    );
        return ce & (~valid | leave);
    endfunction

    // Clear beats load beats leave; otherwise the valid bit holds.
    function automatic logic stage_next_valid(
        input logic clear,
        input logic load,
        input logic leave,
        input logic valid
    );
        if (clear) begin
            return 1'b0;
        end
        if (load) begin
            return 1'b1;
        end
        if (leave) begin
            return 1'b0;
        end
        return valid;
    endfunction

endpackage

// File: rtl/dff_pipe_sr_stage.sv
// One pipeline stage: valid bit plus data register with SR > FLUSH > CE priority.
// Accept/leave come from the top-level ready chain; CE is already folded into them.
module pipe_stage_sr
    import dff_pipe_sr_pkg::*;
#(
    parameter int unsigned      WIDTH  = 8,
    parameter logic [WIDTH-1:0] SRINIT = '0
) (
    input  logic             clk,
    input  logic             sr,
    input  logic             flush,
    input  logic             accept,
    input  logic             leave,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             valid,
    output logic             valid_next,
    output logic [WIDTH-1:0] data
);

    logic load;

    assign load       = accept & up_valid & ~flush;
    assign valid_next = stage_next_valid(sr | flush, load, leave, valid);

    // Data of an invalid stage is deliberately held, so Q keeps its last word.
    always_ff @(posedge clk) begin
        if (sr) begin
            valid <= 1'b0;
            data  <= SRINIT;
        end else begin
            valid <= valid_next;
            if (load) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/dff_pipe_sr.sv
// Elastic DEPTH-stage register pipeline with valid/ready on both sides,
// bubble collapse through a combinational ready chain, and a registered occupancy count.
module dff_pipe_sr
    import dff_pipe_sr_pkg::*;
#(
    parameter int unsigned      WIDTH  = 8,
    parameter int unsigned      DEPTH  = 4,
    parameter logic [WIDTH-1:0] SRINIT = '0
) (
    input  logic                         CLK,
    input  logic                         SR,
    input  logic                         CE,
    input  logic                         FLUSH,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic [WIDTH-1:0]             D,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic [WIDTH-1:0]             Q,
    output logic [$clog2(DEPTH+1)-1:0]   COUNT
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] v_next;
    logic [DEPTH-1:0] accept;
    logic [DEPTH-1:0] leave;
    logic [WIDTH-1:0] d [DEPTH];
    logic [CW-1:0]    count_next;

    // Ready ripples from the output stage back to the input in one cycle.
    always_comb begin
        logic down;
        down   = OUT_READY & CE;
        accept = '0;
        leave  = '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            leave[DEPTH-1-j]  = v[DEPTH-1-j] & down;
            accept[DEPTH-1-j] = stage_accept(CE, v[DEPTH-1-j], leave[DEPTH-1-j]);
            down              = accept[DEPTH-1-j];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;

        if (i == 0) begin : g_head
            assign up_valid = IN_VALID;
            assign up_data  = D;
        end else begin : g_body
            assign up_valid = v[i-1];
            assign up_data  = d[i-1];
        end

        pipe_stage_sr #(
            .WIDTH  (WIDTH),
            .SRINIT (SRINIT)
        ) u_stage (
            .clk        (CLK),
            .sr         (SR),
            .flush      (FLUSH),
            .accept     (accept[i]),
            .leave      (leave[i]),
            .up_valid   (up_valid),
            .up_data    (up_data),
            .valid      (v[i]),
            .valid_next (v_next[i]),
            .data       (d[i])
        );
    end

    always_comb begin
        count_next = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            count_next = count_next + CW'(v_next[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (SR) begin
            COUNT <= '0;
        end else begin
            COUNT <= count_next;
        end
    end

    assign IN_READY  = accept[0] & ~FLUSH & ~SR;
    assign OUT_VALID = v[DEPTH-1] & CE & ~SR;
    assign Q         = d[DEPTH-1];

endmodule

// File: tb/tb_dff_pipe_sr.sv
// Scoreboard bench for dff_pipe_sr (WIDTH=8, DEPTH=4, SRINIT=8'hA5): accepted
// words are queued, and an output monitor pops and compares data and latency.
module tb_dff_pipe_sr;

    localparam int        W    = 8;
    localparam int        DEP  = 4;
    localparam logic [7:0] INIT = 8'hA5;

    logic       CLK = 1'b0;
    logic       SR, CE, FLUSH, IN_VALID, OUT_READY;
    logic       IN_READY, OUT_VALID;
    logic [7:0] D, Q;
    logic [2:0] COUNT;

    dff_pipe_sr #(
        .WIDTH  (W),
        .DEPTH  (DEP),
        .SRINIT (INIT)
    ) dut (
        .CLK       (CLK),
        .SR        (SR),
        .CE        (CE),
        .FLUSH     (FLUSH),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .D         (D),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .Q         (Q),
        .COUNT     (COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] data;
        int         cyc;
        bit         lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   lat_mode = 1'b0;

    always @(posedge CLK) cyc++;

    // Input side: every completed upstream handshake queues its expected word.
    always @(negedge CLK) begin
        if (IN_VALID === 1'b1 && IN_READY === 1'b1 && SR === 1'b0 && FLUSH === 1'b0)
            sb.push_back('{D, cyc, lat_mode});
    end

    // Output side: a downstream transfer happens only without FLUSH.
    always @(negedge CLK) begin
        if (OUT_VALID === 1'b1 && OUT_READY === 1'b1 && FLUSH === 1'b0) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL out_unexpected got=%h want=none", Q);
            end else begin
                mon_e = sb.pop_front();
                if (Q !== mon_e.data) begin
                    bad++;
                    $display("FAIL out_data got=%h want=%h", Q, mon_e.data);
                end
                if (mon_e.lat) begin
                    total++;
                    if (cyc - mon_e.cyc != DEP) begin
                        bad++;
                        $display("FAIL out_latency got=%0d want=%0d", cyc - mon_e.cyc, DEP);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic neg();
        @(negedge CLK);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            tick();
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_drain got=%0d want=0", name, sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        SR = 1'b1; CE = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0; D = 8'h00;

        // reset
        tick();
        neg();
        chk("rst_in_ready", IN_READY, 0);
        chk("rst_out_valid", OUT_VALID, 0);
        tick();
        SR = 1'b0;
        neg();
        chk("rel_in_ready", IN_READY, 1);
        chk("rel_out_valid", OUT_VALID, 0);
        chk("rel_q", Q, INIT);
        chk("rel_count", COUNT, 0);
        tick();

        // back-to-back stream, latency checked by the monitor
        lat_mode  = 1'b1;
        OUT_READY = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            D = 8'(k);
            IN_VALID = 1'b1;
            neg();
            chk("stream_in_ready", IN_READY, 1);
            chk("stream_count", COUNT, (k - 1 < DEP) ? k - 1 : DEP);
            tick();
        end
        IN_VALID = 1'b0;
        lat_mode = 1'b0;
        drain("stream");
        chk("stream_count_end", COUNT, 0);

        // stall: fill to four, then simultaneous in/out when full
        OUT_READY = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            D = 8'h10 + 8'(k);
            IN_VALID = 1'b1;
            neg();
            chk("stall_in_ready", IN_READY, 1);
            tick();
        end
        D = 8'h15;
        for (int k = 0; k < 2; k++) begin
            neg();
            chk("full_in_ready", IN_READY, 0);
            chk("full_count", COUNT, 4);
            chk("full_out_valid", OUT_VALID, 1);
            chk("full_q", Q, 8'h11);
            tick();
        end
        OUT_READY = 1'b1;
        neg();
        chk("full_io_in_ready", IN_READY, 1);
        chk("full_io_count", COUNT, 4);
        tick();
        D = 8'h16;
        neg();
        chk("full_io2_in_ready", IN_READY, 1);
        chk("full_io2_count", COUNT, 4);
        tick();
        IN_VALID = 1'b0;
        drain("stall");
        chk("stall_count_end", COUNT, 0);

        // clock enable freeze mid-stream
        for (int k = 1; k <= 3; k++) begin
            D = 8'h30 + 8'(k);
            IN_VALID = 1'b1;
            neg();
            chk("ce_pre_in_ready", IN_READY, 1);
            tick();
        end
        CE = 1'b0;
        D  = 8'h34;
        for (int k = 0; k < 3; k++) begin
            neg();
            chk("ce_in_ready", IN_READY, 0);
            chk("ce_out_valid", OUT_VALID, 0);
            chk("ce_count", COUNT, 3);
            chk("ce_q", Q, 8'h16);
            tick();
        end
        CE = 1'b1;
        for (int k = 4; k <= 6; k++) begin
            D = 8'h30 + 8'(k);
            neg();
            chk("ce_post_in_ready", IN_READY, 1);
            tick();
        end
        IN_VALID = 1'b0;
        drain("ce");

        // flush with three words held
        OUT_READY = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            D = 8'h40 + 8'(k);
            IN_VALID = 1'b1;
            neg();
            chk("fl_in_ready", IN_READY, 1);
            tick();
        end
        IN_VALID = 1'b0;
        tick();
        neg();
        chk("fl_pre_count", COUNT, 3);
        chk("fl_pre_q", Q, 8'h41);
        chk("fl_pre_out_valid", OUT_VALID, 1);
        tick();
        FLUSH = 1'b1; IN_VALID = 1'b1; D = 8'h44; OUT_READY = 1'b1;
        neg();
        chk("fl_in_ready_blk", IN_READY, 0);
        tick();
        sb.delete();
        FLUSH = 1'b0; IN_VALID = 1'b0;
        neg();
        chk("fl_count", COUNT, 0);
        chk("fl_out_valid", OUT_VALID, 0);
        chk("fl_q_held", Q, 8'h41);
        tick();

        // SR together with FLUSH reloads SRINIT
        OUT_READY = 1'b0; D = 8'h45; IN_VALID = 1'b1;
        neg();
        tick();
        IN_VALID = 1'b0; SR = 1'b1; FLUSH = 1'b1;
        neg();
        chk("srfl_in_ready", IN_READY, 0);
        chk("srfl_out_valid", OUT_VALID, 0);
        tick();
        sb.delete();
        SR = 1'b0; FLUSH = 1'b0;
        neg();
        chk("srfl_q", Q, INIT);
        chk("srfl_count", COUNT, 0);
        chk("srfl_out_valid_after", OUT_VALID, 0);
        tick();

        // single word after reset
        OUT_READY = 1'b1; lat_mode = 1'b1; D = 8'h51; IN_VALID = 1'b1;
        neg();
        chk("last_in_ready", IN_READY, 1);
        tick();
        IN_VALID = 1'b0;
        drain("last");
        chk("last_count", COUNT, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
